// File: rtl/mdu_defs.sv
// Shared mdop encodings, default latencies and FSM state type for the
// multiply/divide unit; also included by the controller and hazard unit.
package mdu_defs;

  localparam logic [2:0] MDOP_MULT  = 3'b000;
  localparam logic [2:0] MDOP_MULTU = 3'b001;
  localparam logic [2:0] MDOP_DIV   = 3'b010;
  localparam logic [2:0] MDOP_DIVU  = 3'b011;
  localparam logic [2:0] MDOP_MTHI  = 3'b100;
  localparam logic [2:0] MDOP_MTLO  = 3'b101;
  localparam logic [2:0] MDOP_MADD  = 3'b110;
  localparam logic [2:0] MDOP_MADDU = 3'b111;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO.
// Define MDU_MADD_EN to enable the MADD/MADDU accumulate ops (mdop 110/111).
module mdu_unit
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q, res_hi_q, res_lo_q;
  logic [31:0] res_hi_d, res_lo_d;
  logic        is_mul, is_div;
  logic [63:0] prod_s, prod_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Result defaults to the current HI/LO so a divide by zero commits no change.
  always_comb begin
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    is_mul   = 1'b0;
    is_div   = 1'b0;
    case (mdop)
      MDOP_MULT: begin
        is_mul = 1'b1;
        {res_hi_d, res_lo_d} = prod_s;
      end
      MDOP_MULTU: begin
        is_mul = 1'b1;
        {res_hi_d, res_lo_d} = prod_u;
      end
      MDOP_DIV: begin
        is_div = 1'b1;
        if (B != 32'd0) begin
          if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            res_lo_d = 32'h8000_0000;
            res_hi_d = 32'd0;
          end else begin
            res_lo_d = $signed(A) / $signed(B);
            res_hi_d = $signed(A) % $signed(B);
          end
        end
      end
      MDOP_DIVU: begin
        is_div = 1'b1;
        if (B != 32'd0) begin
          res_lo_d = A / B;
          res_hi_d = A % B;
        end
      end
`ifdef MDU_MADD_EN
      MDOP_MADD: begin
        is_mul = 1'b1;
        {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_s;
      end
      MDOP_MADDU: begin
        is_mul = 1'b1;
        {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_u;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            if (mdop == MDOP_MTHI) begin
              hi_q <= A;
            end else if (mdop == MDOP_MTLO) begin
              lo_q <= A;
            end else if (is_mul || is_div) begin
              res_hi_q <= res_hi_d;
              res_lo_q <= res_lo_d;
              cnt_q    <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              state_q  <= MDU_RUN;
              busy_q   <= 1'b1;
            end
          end
        end
        MDU_RUN: begin
          if (cnt_q == CW'(1)) begin
            hi_q    <= res_hi_q;
            lo_q    <= res_lo_q;
            cnt_q   <= '0;
            state_q <= MDU_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit; build with +define+MDU_MADD_EN to exercise MADD/MADDU.
module tb_mdu_unit;

  import mdu_defs::*;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi_out, lo_out;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mdu_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi_out(hi_out),
    .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, push its expected outcome, then count busy cycles and
  // pop/compare once the unit is idle. injectAt>0 fires an MTLO on that busy cycle.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo, input int expCycles, input int injectAt);
    exp_t e;
    int   n;
    e.tag = tag; e.hi = expHi; e.lo = expLo; e.cycles = expCycles;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; mdop = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == injectAt) begin
        start = 1'b1; mdop = MDOP_MTLO; A = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    checkOutput({e.tag, ".cycles"}, 64'(n), 64'(e.cycles));
    checkOutput({e.tag, ".hi"}, {32'd0, hi_out}, {32'd0, e.hi});
    checkOutput({e.tag, ".lo"}, {32'd0, lo_out}, {32'd0, e.lo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdop = 3'b000; A = '0; B = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst.busy", {63'd0, busy}, 64'd0);
    checkOutput("rst.hi", {32'd0, hi_out}, 64'd0);
    checkOutput("rst.lo", {32'd0, lo_out}, 64'd0);
    reset = 1'b0;

    // Abort a running MULT with reset; nothing may commit afterward.
    @(negedge clk);
    start = 1'b1; mdop = MDOP_MULT; A = 32'hFFFF_FFFF; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    checkOutput("abort.busy_pre", {63'd0, busy}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort.busy", {63'd0, busy}, 64'd0);
    checkOutput("abort.hi", {32'd0, hi_out}, 64'd0);
    checkOutput("abort.lo", {32'd0, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("abort.after_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort.after_hi", {32'd0, hi_out}, 64'd0);
    checkOutput("abort.after_lo", {32'd0, lo_out}, 64'd0);

    applyStimulus("mult",   MDOP_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 0);
    applyStimulus("multu",  MDOP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1,         32'hFFFF_FFFE, 5, 0);
    applyStimulus("div",    MDOP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
    applyStimulus("divu",   MDOP_DIVU,  32'd7,         32'd2, 32'd1,         32'd3,         10, 0);
    applyStimulus("divovf", MDOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0);
    applyStimulus("mthi5",  MDOP_MTHI,  32'd5,         32'd0, 32'd5,         32'h8000_0000, 0, 0);
    applyStimulus("mtlo6",  MDOP_MTLO,  32'd6,         32'd0, 32'd5,         32'd6,         0, 0);
    applyStimulus("divz",   MDOP_DIVU,  32'd9,         32'd0, 32'd5,         32'd6,         10, 0);
    applyStimulus("mthi",   MDOP_MTHI,  32'h1234_5678, 32'd0, 32'h1234_5678, 32'd6,         0, 0);
    applyStimulus("mtlo_mid",  MDOP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5, 2);
    applyStimulus("mtlo_last", MDOP_MULT,  32'd5, 32'd6, 32'd0, 32'd30, 5, 5);
    applyStimulus("neg_mult",  MDOP_MULT,  32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5, 0);

    applyStimulus("madd_hi", MDOP_MTHI, 32'd0,         32'd0, 32'd0, 32'hFFFF_FFF4, 0, 0);
    applyStimulus("madd_lo", MDOP_MTLO, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0);
`ifdef MDU_MADD_EN
    applyStimulus("maddu", MDOP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
    applyStimulus("madd",  MDOP_MADD,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 5, 0);
`else
    applyStimulus("maddu", MDOP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 0);
    applyStimulus("madd",  MDOP_MADD,  32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 0);
`endif

    checkOutput("sb.empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide unit for the MIPS datapath, sitting beside the single-cycle ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the controller, models the fixed latency of a hardware multiplier or divider with a busy counter, and holds the architectural HI/LO registers read by MFHI/MFLO. The hazard unit stalls on `busy` or on `start` for the whole multi-cycle window.

## Interface
- `MULT_CYCLES`, 5: cycles `busy` stays high for MULT/MULTU (and MADD/MADDU when compiled in); must be ≥ 1.
- `DIV_CYCLES`, 10: cycles `busy` stays high for DIV/DIVU; must be ≥ 1.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle request strobe, qualified by `mdop`.
- `mdop`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `busy`  out  1  high while a MULT/DIV-class operation is in progress.
- `hi_out`  out  32  architectural HI.
- `lo_out`  out  32  architectural LO.

## Operation
- FSM with two states: IDLE, RUN. Down-counter `cnt` with width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)).
- In IDLE, when `start` is high at the edge:
  - MTHI writes HI ← A.
  - MTLO writes LO ← A.
  - Neither MTHI nor MTLO changes state.
- In IDLE, for MULT-class or DIV-class ops at the start edge:
  - Compute the result from A/B and latch it into `res_hi`/`res_lo`.
  - Set `cnt` to MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- Arithmetic:
  - MULT: 64-bit signed product.
  - MULTU: 64-bit unsigned product. Result {HI, LO} = product.
  - DIV: signed; quotient truncates toward zero into LO; remainder takes the dividend's sign into HI.
  - DIVU: unsigned; quotient into LO, remainder into HI.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B = 0): the operation runs its full DIV_CYCLES; HI/LO keep their previous values.
- In RUN:
  - `cnt` decrements each edge.
  - On the edge where `cnt` = 1, `res_hi`/`res_lo` commit to HI/LO, `cnt` → 0, and the FSM goes to IDLE.
- `start` while in RUN (any `mdop`) is ignored; HI/LO and the counter are unaffected.
- Reset at any time, including mid-RUN, aborts the operation. The result is discarded and the FSM goes to IDLE.

## Timing
- Reset values: `busy` = 0; `hi_out` = 0; `lo_out` = 0; state IDLE; `cnt` = 0.
- `busy` is a registered output, equal to (state == RUN).
- For a start sampled at edge T:
  - `busy` is high from after T until after edge T+N, where N is the cycle count.
  - The new HI/LO are visible after edge T+N, in the same cycle `busy` falls.
- A back-to-back start is accepted at edge T+N+1 at the earliest. A start at edge T+N is ignored because `busy` is still 1 during that cycle.
- MTHI/MTLO take effect after a single edge; `busy` stays 0.
- `hi_out`/`lo_out` are direct register outputs with no combinational path from inputs. An MFHI in the same cycle as an MTHI start reads the old value.

## Configuration
- `MDU_MADD_EN` defined:
  - mdop 110 (MADD) runs MULT_CYCLES and commits {HI, LO} ← {HI, LO} + signed(A×B).
  - mdop 111 (MADDU) does the same with the unsigned product.
  - The accumulate uses HI/LO as they stand at the start edge, with 64-bit wrap-around.
- `MDU_MADD_EN` undefined: mdop 110/111 with `start` are ignored; no state change and `busy` stays 0.

## Structure
- Shared package/header `mdu_defs`:
  - mdop encodings `MDOP_MULT` … `MDOP_MADDU`.
  - Defaults for MULT_CYCLES/DIV_CYCLES.
  - State encodings `MDU_IDLE` and `MDU_RUN`.
  - The controller and hazard unit include the same header.
- No sub-module; a single flat module holding the FSM, counter, result latch and HI/LO.

## Test plan
- After reset: `busy` = 0, `hi_out` = 0, `lo_out` = 0. Assert reset mid-RUN: all three return to 0 immediately, with no commit afterward.
- MULT A=0xFFFFFFFF, B=2: `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands gives HI=1, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2: `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 gives LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. DIVU with B=0 after HI=5, LO=6: after 10 cycles, HI=5 and LO=6.
- MTHI A=0x12345678 gives HI=0x12345678 one edge later with `busy` never high. An MTLO issued during a running MULT is ignored: LO ends at the product.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 gives HI=1, LO=0. Without the macro, the same stimulus leaves `busy`=0 and HI/LO unchanged.
